// File: rtl/sp_ram_ctrl.sv
// Request-side controller for a single-port synchronous RAM: valid/ready request in,
// cs/we/oe strobe sequencing and bidirectional data bus out, read response channel back.
module sp_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive;
    logic                  accept_c;
    logic                  in_range_c;
    logic                  cs_c;
    logic                  we_c;
    logic                  oe_c;

    assign accept_c   = req_valid & req_ready;
    assign in_range_c = 32'(req_addr) < DEPTH;

    // Controller only drives the bus while the RAM is being written (oe low).
    assign ram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // Next-state and strobe decode; strobes are registered from the next state.
    always_comb begin
        next_state = state;
        cs_c       = 1'b0;
        we_c       = 1'b0;
        oe_c       = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (req_write) next_state = in_range_c ? WRITE : IDLE;
                    else           next_state = in_range_c ? RD_ADDR : RSP;
                end
            end
            WRITE:   next_state = IDLE;
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: next_state = RSP;
            RSP:     if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        case (next_state)
            WRITE:   begin cs_c = 1'b1; we_c = 1'b1; end
            RD_ADDR: cs_c = 1'b1;
            RD_DATA: begin cs_c = 1'b1; oe_c = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            drive     <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= next_state;
            ram_cs    <= cs_c;
            ram_we    <= we_c;
            ram_oe    <= oe_c;
            drive     <= (next_state == WRITE);
            req_ready <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            if (accept_c) begin
                ram_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            // Response channel: held in RSP until handshake, otherwise pulses/loads.
            if (state == RSP) begin
                if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            end else begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                if (state == IDLE && accept_c && !in_range_c) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_valid <= !req_write;
                end else if (state == RD_DATA) begin
                    rsp_rdata <= ram_data;
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

endmodule
